// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// signed or unsigned, one bit per cycle behind a start/busy/done handshake.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_zero
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic [WIDTH-1:0] r_src1;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH:0]   r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_accept;
    logic             w_signed;
    logic             w_neg1;
    logic             w_neg2;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;

    // Magnitudes are taken as unsigned WIDTH-bit values, so |-2^(WIDTH-1)| fits.
    assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && start && !flush;
    assign w_signed = !op[0];
    assign w_neg1   = w_signed && src1[WIDTH-1];
    assign w_neg2   = w_signed && src2[WIDTH-1];
    assign w_mag1   = w_neg1 ? -src1 : src1;
    assign w_mag2   = w_neg2 ? -src2 : src2;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH+1:0] w_diff;
    logic [WIDTH:0]   w_hi_nx;
    logic [WIDTH-1:0] w_lo_nx;

    assign w_mul_sum = r_hi + (r_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_rem_sh  = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
    assign w_diff    = {1'b0, w_rem_sh} - {2'b00, r_opnd};

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_hi_nx = {1'b0, w_mul_sum[WIDTH:1]};
        w_lo_nx = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        if (r_is_div) begin
            if (!w_diff[WIDTH+1]) begin
                w_hi_nx = w_diff[WIDTH:0];
                w_lo_nx = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_hi_nx = w_rem_sh;
                w_lo_nx = {r_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    // A signed product is negated as one 2*WIDTH value so the borrow reaches the high half.
    assign w_prod     = {r_hi[WIDTH-1:0], r_lo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

    always_comb begin
        w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod_fix[WIDTH-1:0];
        if (r_dz) begin
            w_fix_hi = r_src1;
            w_fix_lo = '1;
        end else if (r_is_div) begin
            w_fix_hi = r_neg_r ? -r_hi[WIDTH-1:0] : r_hi[WIDTH-1:0];
            w_fix_lo = r_neg_q ? -r_lo : r_lo;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_state_nx = w_accept ? S_RUN : S_IDLE;
            S_RUN: begin
                if (flush) begin
                    w_state_nx = S_IDLE;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_state_nx = S_FIX;
                end
            end
            S_FIX:   w_state_nx = flush ? S_IDLE : S_DONE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz      <= 1'b0;
            r_src1    <= '0;
            r_opnd    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result_hi <= '0;
            result_lo <= '0;
            div_zero  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            busy    <= (w_state_nx == S_RUN) || (w_state_nx == S_FIX);
            done    <= (w_state_nx == S_DONE);
            if (w_accept) begin
                r_cnt    <= CNT_W'(WIDTH);
                r_is_div <= op[1];
                r_neg_q  <= w_neg1 ^ w_neg2;
                r_neg_r  <= op[1] && w_neg1;
                r_dz     <= op[1] && (src2 == '0);
                r_src1   <= src1;
                r_hi     <= '0;
                r_lo     <= op[1] ? w_mag1 : w_mag2;
                r_opnd   <= op[1] ? w_mag2 : w_mag1;
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt - 1'b1;
                r_hi  <= w_hi_nx;
                r_lo  <= w_lo_nx;
            end
            if ((r_state == S_FIX) && !flush) begin
                result_hi <= w_fix_hi;
                result_lo <= w_fix_lo;
                div_zero  <= r_dz;
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: a 32-bit and an 8-bit instance checked against
// a plain-arithmetic model, with directed corners and randomized traffic.
module tb_mdu_iter;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULU = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_DIVU = 2'b11;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } res_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start_i [2];
    logic        flush_i [2];
    logic [1:0]  op_i    [2];
    logic [31:0] s1_i    [2];
    logic [31:0] s2_i    [2];

    logic        busy32, done32, dz32;
    logic [31:0] hi32, lo32;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;

    int   n_cmp = 0;
    int   n_bad = 0;
    res_t exp_q0[$];
    res_t exp_q1[$];
    res_t last_r [2];

    mdu_iter #(.WIDTH(32)) u_dut32 (
        .clk(clk), .resetn(resetn), .start(start_i[0]), .op(op_i[0]),
        .src1(s1_i[0]), .src2(s2_i[0]), .flush(flush_i[0]),
        .busy(busy32), .done(done32), .result_hi(hi32), .result_lo(lo32), .div_zero(dz32)
    );

    mdu_iter #(.WIDTH(8)) u_dut8 (
        .clk(clk), .resetn(resetn), .start(start_i[1]), .op(op_i[1]),
        .src1(s1_i[1][7:0]), .src2(s2_i[1][7:0]), .flush(flush_i[1]),
        .busy(busy8), .done(done8), .result_hi(hi8), .result_lo(lo8), .div_zero(dz8)
    );

    always #5 clk = ~clk;

    function automatic int width_of(input int d);
        return (d == 0) ? 32 : 8;
    endfunction
    function automatic logic f_busy(input int d);
        return (d == 0) ? busy32 : busy8;
    endfunction
    function automatic logic f_done(input int d);
        return (d == 0) ? done32 : done8;
    endfunction
    function automatic res_t f_res(input int d);
        res_t r;
        r.hi = (d == 0) ? hi32 : {24'h0, hi8};
        r.lo = (d == 0) ? lo32 : {24'h0, lo8};
        r.dz = (d == 0) ? dz32 : dz8;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: signed/unsigned product or quotient/remainder straight from 64-bit arithmetic.
    function automatic res_t model(input int w, input logic [1:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        res_t        r;
        logic [63:0] m, ua, ub, p;
        longint      sa, sb, q, rm;
        m  = (64'd1 << w) - 64'd1;
        ua = {32'h0, a} & m;
        ub = {32'h0, b} & m;
        sa = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
        sb = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
        r.dz = 1'b0;
        p = '0;
        case (op)
            OP_MUL:  p = sa * sb;
            OP_MULU: p = ua * ub;
            default: begin
                if (ub == 64'd0) begin
                    p    = (ua << w) | m;
                    r.dz = 1'b1;
                end else if (op == OP_DIV) begin
                    q  = sa / sb;
                    rm = sa % sb;
                    p  = ((64'(rm) & m) << w) | (64'(q) & m);
                end else begin
                    p = (((ua % ub) & m) << w) | ((ua / ub) & m);
                end
            end
        endcase
        r.hi = 32'((p >> w) & m);
        r.lo = 32'(p & m);
        return r;
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return m;
            3:       return 32'd1 << (w - 1);
            4:       return (32'd1 << (w - 1)) - 32'd1;
            default: return $urandom & m;
        endcase
    endfunction

    // Compare process: every cycle either a done with the next expected result,
    // or results held at the last completed value; reset values while resetn is low.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            res_t got, e;
            got = f_res(d);
            if (!resetn) begin
                check("rst_busy", 64'(f_busy(d)), 64'd0);
                check("rst_done", 64'(f_done(d)), 64'd0);
                check("rst_res", 64'(got), 64'd0);
                last_r[d] = '0;
                if (d == 0) exp_q0.delete(); else exp_q1.delete();
            end else if (f_done(d)) begin
                if ((d == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: dut%0d got done=1 expected none", d);
                end else begin
                    e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    check("res_hi", 64'(got.hi), 64'(e.hi));
                    check("res_lo", 64'(got.lo), 64'(e.lo));
                    check("res_dz", 64'(got.dz), 64'(e.dz));
                    last_r[d] = e;
                end
            end else begin
                check("hold_res", 64'(got), 64'(last_r[d]));
            end
        end
    end

    task automatic idle(input int d, input int n);
        repeat (n) begin
            @(posedge clk); #1;
            check("idle_busy", 64'(f_busy(d)), 64'd0);
        end
    endtask

    // Issue one op in the current cycle (cycle 0); cycle k begins at the k-th edge after.
    // Returns in the done cycle, or in the cycle after the flush was sampled.
    task automatic run_op(input int d, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int flush_at, input int poke_at);
        int   w;
        int   lat;
        bit   seen;
        res_t e;
        w    = width_of(d);
        lat  = 0;
        seen = 1'b0;
        e    = model(w, op, a, b);
        if (flush_at < 0) begin
            if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        end
        start_i[d] = 1'b1;
        op_i[d]    = op;
        s1_i[d]    = a;
        s2_i[d]    = b;
        while (!seen && lat < w + 8) begin
            @(posedge clk); #1;
            lat++;
            start_i[d] = 1'b0;
            flush_i[d] = 1'b0;
            op_i[d]    = 2'($urandom_range(0, 3));
            s1_i[d]    = $urandom;
            s2_i[d]    = $urandom;
            if (flush_at >= 0 && lat == flush_at + 1) begin
                check("flush_busy", 64'(f_busy(d)), 64'd0);
                return;
            end
            if (f_done(d)) begin
                seen = 1'b1;
                check("latency", 64'(lat), 64'(w + 2));
                check("busy_at_done", 64'(f_busy(d)), 64'd0);
            end else begin
                check("busy_run", 64'(f_busy(d)), 64'd1);
            end
            if (lat == flush_at) flush_i[d] = 1'b1;
            if (lat == poke_at)  start_i[d] = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: dut%0d no done within %0d cycles", d, w + 8);
        end
    endtask

    initial begin
        res_t e;
        for (int d = 0; d < 2; d++) begin
            start_i[d] = 1'b0;
            flush_i[d] = 1'b0;
            op_i[d]    = 2'b00;
            s1_i[d]    = '0;
            s2_i[d]    = '0;
            last_r[d]  = '0;
        end

        // Model pinned to hand-computed values.
        e = model(32, OP_MUL, 32'hFFFF_FFFD, 32'd5);
        check("model_mul", {e.hi, e.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        e = model(32, OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("model_mulu", {e.hi, e.lo}, 64'hFFFF_FFFE_0000_0001);
        e = model(32, OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check("model_div", {e.hi, e.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        e = model(32, OP_DIVU, 32'd100, 32'd7);
        check("model_divu", {e.hi, e.lo}, {32'd2, 32'd14});
        e = model(32, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("model_ovf", {e.hi, e.lo}, 64'h0000_0000_8000_0000);
        e = model(32, OP_DIVU, 32'h1234, 32'd0);
        check("model_dz", {31'd0, e.dz, e.hi}, {31'd0, 1'b1, 32'h1234});
        e = model(8, OP_DIV, 32'h80, 32'hFF);
        check("model_ovf8", {e.hi, e.lo}, {32'h0, 32'h80});

        repeat (2) @(posedge clk);
        #1;
        check("por_busy", 64'(busy32), 64'd0);
        check("por_res", 64'({hi32, lo32}), 64'd0);
        resetn = 1'b1;
        idle(0, 2);

        run_op(0, OP_MUL, 32'hFFFF_FFFD, 32'd5, -1, -1);
        check("mul_lit", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFF1);
        idle(0, 2);

        // Asynchronous reset in the middle of a MULU.
        start_i[0] = 1'b1; op_i[0] = OP_MULU; s1_i[0] = 32'd7; s2_i[0] = 32'd9;
        repeat (10) begin
            @(posedge clk); #1;
            start_i[0] = 1'b0;
        end
        resetn = 1'b0;
        #1;
        check("arst_busy", 64'(busy32), 64'd0);
        check("arst_done", 64'(done32), 64'd0);
        check("arst_res", {hi32, lo32}, 64'd0);
        check("arst_dz", 64'(dz32), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b1;
        idle(0, 40);

        run_op(0, OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
        run_op(0, OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, -1);
        idle(0, 1);
        run_op(0, OP_DIVU, 32'd100, 32'd7, -1, -1);
        run_op(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
        run_op(0, OP_DIVU, 32'h1234, 32'd0, -1, -1);
        check("dz_lit", {31'd0, dz32, hi32}, {31'd0, 1'b1, 32'h1234});
        idle(0, 3);
        run_op(0, OP_MUL, 32'd6, 32'hFFFF_FFF9, -1, -1);
        check("dz_clear", 64'(dz32), 64'd0);

        // Start pulsed while busy must not queue a second operation.
        idle(0, 2);
        run_op(0, OP_MULU, 32'd1000, 32'd3000, -1, 5);
        idle(0, 40);

        // Back-to-back: the second run_op starts in the DONE cycle of the first.
        run_op(0, OP_DIVU, 32'hDEAD_BEEF, 32'd13, -1, -1);
        run_op(0, OP_DIV, 32'h8000_0001, 32'd3, -1, -1);

        // Flush in RUN, flush in FIX, and flush together with start in IDLE.
        run_op(0, OP_DIVU, 32'd999, 32'd5, 20, -1);
        idle(0, 40);
        run_op(0, OP_MUL, 32'd12, 32'd12, 33, -1);
        idle(0, 40);
        start_i[0] = 1'b1; flush_i[0] = 1'b1; op_i[0] = OP_MULU;
        s1_i[0] = 32'd3; s2_i[0] = 32'd4;
        @(posedge clk); #1;
        start_i[0] = 1'b0; flush_i[0] = 1'b0;
        check("flush_start_busy", 64'(busy32), 64'd0);
        idle(0, 40);

        // WIDTH=8 corners then randomized traffic with random gaps and flushes.
        run_op(1, OP_DIV, 32'h80, 32'hFF, -1, -1);
        check("ovf8_lit", {hi8, lo8}, 16'h0080);
        run_op(1, OP_DIV, 32'h85, 32'h00, -1, -1);
        run_op(1, OP_DIVU, 32'hF0, 32'h00, -1, -1);
        run_op(1, OP_MUL, 32'h80, 32'h80, -1, -1);
        run_op(1, OP_MULU, 32'hFF, 32'hFF, -1, -1);
        for (int i = 0; i < 250; i++) begin
            int fl;
            int gap;
            fl  = ($urandom_range(0, 15) == 0) ? $urandom_range(1, 9) : -1;
            gap = $urandom_range(0, 2);
            run_op(1, 2'($urandom_range(0, 3)), pick(8), pick(8), fl, -1);
            if (gap > 0) idle(1, gap);
        end

        for (int i = 0; i < 25; i++) begin
            run_op(0, 2'($urandom_range(0, 3)), pick(32), pick(32), -1, -1);
        end

        idle(0, 4);
        check("q0_drained", 64'(exp_q0.size()), 64'd0);
        check("q1_drained", 64'(exp_q1.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised iterative multiply/divide unit. It is the next generation of the single-cycle datapath's multi-cycle multiply path, which only handled 32-bit signed MUL with an end flag. It supports signed and unsigned multiply and divide at any even width, with a start/busy/done handshake. The unit sits beside the ALU in the execute stage; the core stalls while `busy` is high and writes back on `done`.

## Interface
- `WIDTH`, 32: operand width; even, ≥ 4.
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width.

- `clk` in 1: CPU clock; all state changes on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only when `busy`=0.
- `op` in 2: operation select.
  - 00 MUL (signed × signed)
  - 01 MULU (unsigned)
  - 10 DIV (signed)
  - 11 DIVU (unsigned)
- `src1` in WIDTH: multiplicand / dividend.
- `src2` in WIDTH: multiplier / divisor.
- `flush` in 1: synchronous cancel of the operation in flight.
- `busy` out 1: high in RUN and FIX.
- `done` out 1: one-cycle pulse; results valid.
- `result_hi` out WIDTH: product upper half / remainder.
- `result_lo` out WIDTH: product lower half / quotient.
- `div_zero` out 1: last completed divide had `src2`=0; held with the results.

## Operation
- FSM states: IDLE, RUN, FIX, DONE.
- **Accept.** In IDLE or DONE with `start`=1 and `flush`=0, the unit latches `op`, the operand magnitudes and both operand signs, loads counter = WIDTH, and goes to RUN.
- **Sign handling.** Signed ops take absolute values.
  - Result sign for MUL and DIV quotient: `src1`[MSB] ^ `src2`[MSB].
  - Remainder sign: `src1`[MSB].
  - The unsigned magnitude datapath is WIDTH bits plus 1 guard bit, so |−2^(WIDTH−1)| is representable.
- **RUN, multiply.**
  - Radix-2 shift-add: if acc_lo[0] is set, add the multiplicand to acc_hi (WIDTH+1 bits), then shift {acc_hi, acc_lo} right by 1.
  - One bit per cycle; counter decrements each cycle.
- **RUN, divide.**
  - Restoring: shift {rem, quo} left by 1.
  - Trial-subtract the divisor from rem. If the result is non-negative, keep it and set quo[0]=1; otherwise restore.
- **FIX.** Leave RUN when counter reaches 1 after its final iteration. FIX then:
  - applies two's-complement negation to each result half where the sign rule requires it;
  - registers `result_hi`, `result_lo` and `div_zero`;
  - moves to DONE.
- **DONE.** `done`=1 for exactly this cycle. The next edge goes to IDLE, or to RUN if `start` is asserted.
- **Divide by zero** (DIV/DIVU with `src2`=0):
  - Takes the same full latency.
  - Result forced: `result_lo` = all ones, `result_hi` = `src1` (unmodified), `div_zero`=1.
- **Signed overflow** (DIV of −2^(WIDTH−1) by −1):
  - `result_lo` = −2^(WIDTH−1), `result_hi` = 0.
  - `div_zero`=0; no trap.
- **Start handling.** `start` while `busy`=1 is ignored, not queued. Operands need only be stable in the accepting cycle.
- **Flush.**
  - In RUN or FIX: the next state is IDLE, no `done` is produced, and `result_*`/`div_zero` keep their previous values.
  - In IDLE or DONE: blocks acceptance that cycle.
  - Flush has priority over `start`.
- **Reset.** Asserting `resetn` low at any time, including mid-operation, immediately returns the unit to the reset state below.

## Timing
- Reset values:
  - state = IDLE, counter = 0;
  - `busy`=0, `done`=0;
  - `result_hi` = `result_lo` = 0, `div_zero`=0.
- Latency:
  - Start sampled at edge E0 → RUN for edges E1..E_WIDTH.
  - FIX state is between E_WIDTH and E_WIDTH+1.
  - `done` is high in the cycle after E_WIDTH+1, i.e. WIDTH+2 cycles after the start cycle. For WIDTH=32, `done` comes 34 cycles after start.
- `busy` rises the cycle after acceptance and falls in the same cycle `done` rises.
- Back-to-back issue: `start` in the DONE cycle starts a new operation with no idle gap, for a throughput of one operation per WIDTH+2 cycles.
- `result_*` change only at the edge entering DONE and are stable otherwise. The core may read them any time after `done`.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- **Reset mid-run.** MULU 7×9, then drop `resetn` at cycle 10 → all outputs 0 immediately. After release: IDLE, `busy`=0, no `done`.
- **Multiply, WIDTH=32.**
  - MUL −3 × 5 → `done` at cycle 34; hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
  - MULU 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001.
- **Divide.**
  - DIV −7 / 2 → lo = 0xFFFFFFFD (−3), hi = 0xFFFFFFFF (−1).
  - DIVU 100 / 7 → lo = 14, hi = 2.
  - DIV 0x80000000 / −1 → lo = 0x80000000, hi = 0.
- **Divide by zero.** DIVU 0x1234 / 0 → lo = 0xFFFFFFFF, hi = 0x1234, `div_zero`=1. A following MUL clears `div_zero` to 0.
- **Handshake.**
  - `start` pulsed during `busy` → ignored; only one `done`.
  - `start` in the DONE cycle → second `done` exactly 34 cycles later.
- **Flush.** Flush at cycle 20 of DIVU → IDLE next cycle, no `done`, previous results unchanged. `flush` and `start` together in IDLE → not accepted.
- **Parameter sweep.** WIDTH=8 with random ops and operands vs. a reference model. Check `done` at cycle 10, including the −128/−1 and /0 corners.
